exec_unit: RTL



---
 rtl/exec_unit.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/exec_unit.sv
// rtl/exec_unit.sv - registered RV32I execute stage with valid/ready handshakes
// Optional iterative shift-add multiplier (MUL/MULH/MULHSU/MULHU) enabled by EXEC_MUL_EN.
module exec_unit #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [XLEN-1:0] imm,
    input  logic            alu_src,
    input  logic [1:0]      alu_op,
    input  logic [6:0]      func7,
    input  logic [2:0]      func3,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

`ifdef EXEC_MUL_EN
    localparam logic [6:0] F7_MUL  = 7'b0000001;
    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_MUL} state_e;
`else
    typedef enum logic {S_IDLE, S_HOLD} state_e;
`endif

    state_e          state_q;
    logic [XLEN-1:0] result_q;
    logic            illegal_q;

    logic [XLEN-1:0] b_val;
    logic [XLEN-1:0] sra_res;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] result_d;
    logic            illegal_d;
    logic            accept;

    assign b_val   = alu_src ? imm : op_b;
    assign shamt   = b_val[SHW-1:0];
    assign sra_res = $unsigned($signed(op_a) >>> shamt);

`ifdef EXEC_MUL_EN
    logic                mul_d;
    logic [2*XLEN-1:0]   prod_q;
    logic [2*XLEN-1:0]   prod_d;
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     mcand_q;
    logic [XLEN-1:0]     a_mag;
    logic [XLEN-1:0]     b_mag;
    logic [XLEN:0]       mul_sum;
    logic [SHW-1:0]      cnt_q;
    logic                neg_q;
    logic                hi_q;
    logic                a_sgn;
    logic                b_sgn;
    logic                a_neg;
    logic                b_neg;

    // MUL (000) runs unsigned: the low half is identical either way
    assign a_sgn = (func3[1:0] == 2'b01) || (func3[1:0] == 2'b10);
    assign b_sgn = (func3[1:0] == 2'b01);
    assign a_neg = a_sgn & op_a[XLEN-1];
    assign b_neg = b_sgn & op_b[XLEN-1];
    assign a_mag = a_neg ? -op_a : op_a;
    assign b_mag = b_neg ? -op_b : op_b;

    // Multiplier sits in the low half and shifts out as product bits shift in
    assign mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]}
                    + (prod_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
    assign prod_d   = {mul_sum, prod_q[XLEN-1:1]};
    assign prod_fix = neg_q ? -prod_d : prod_d;
`endif

    always_comb begin
        result_d  = '0;
        illegal_d = 1'b0;
`ifdef EXEC_MUL_EN
        mul_d     = 1'b0;
`endif
        case (alu_op)
            2'b00: result_d = op_a + b_val;
            2'b01: result_d = op_a - b_val;
            2'b10: begin
                if (!alu_src) begin
                    if (func7 == F7_ALT)
                        illegal_d = !((func3 == 3'b000) || (func3 == 3'b101));
`ifdef EXEC_MUL_EN
                    else if (func7 == F7_MUL) begin
                        mul_d     = !func3[2];
                        illegal_d = func3[2];
                    end
`endif
                    else if (func7 != F7_BASE)
                        illegal_d = 1'b1;
                end else begin
                    if (func3 == 3'b001)
                        illegal_d = (func7 != F7_BASE);
                    else if (func3 == 3'b101)
                        illegal_d = !((func7 == F7_BASE) || (func7 == F7_ALT));
                end
                case (func3)
                    3'b000: result_d = (!alu_src && func7 == F7_ALT) ? op_a - b_val
                                                                      : op_a + b_val;
                    3'b001: result_d = op_a << shamt;
                    3'b010: result_d = XLEN'($signed(op_a) < $signed(b_val));
                    3'b011: result_d = XLEN'(op_a < b_val);
                    3'b100: result_d = op_a ^ b_val;
                    3'b101: result_d = func7[5] ? sra_res : (op_a >> shamt);
                    3'b110: result_d = op_a | b_val;
                    default: result_d = op_a & b_val;
                endcase
            end
            default: illegal_d = 1'b1;
        endcase
        if (illegal_d)
            result_d = '0;
    end

    assign out_valid = (state_q == S_HOLD);
    assign in_ready  = (state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready);
    assign accept    = in_valid & in_ready;
    assign result    = result_q;
    assign illegal   = illegal_q;
    assign zero      = (result_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            result_q  <= '0;
            illegal_q <= 1'b0;
`ifdef EXEC_MUL_EN
            prod_q    <= '0;
            mcand_q   <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            hi_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_HOLD: begin
                    if (accept) begin
`ifdef EXEC_MUL_EN
                        if (mul_d) begin
                            state_q <= S_MUL;
                            mcand_q <= a_mag;
                            prod_q  <= {{XLEN{1'b0}}, b_mag};
                            cnt_q   <= '0;
                            neg_q   <= a_neg ^ b_neg;
                            hi_q    <= (func3[1:0] != 2'b00);
                        end else
`endif
                        begin
                            state_q   <= S_HOLD;
                            result_q  <= result_d;
                            illegal_q <= illegal_d;
                        end
                    end else if ((state_q == S_HOLD) && out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
`ifdef EXEC_MUL_EN
                S_MUL: begin
                    prod_q <= prod_d;
                    if (cnt_q == SHW'(XLEN-1)) begin
                        state_q   <= S_HOLD;
                        result_q  <= hi_q ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
                        illegal_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + SHW'(1);
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
